// File: rtl/counter_checker.sv
// On-chip checker for the WIDTH-bit enable/sync-reset up-counter: tracks a reference
// count from the counter's own reset/enable and compares it against the counter output.
module counter_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned RUN_CYCLES  = 50,
    parameter int unsigned STOP_ON_ERR = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_reset,
    input  logic             dut_enable,
    input  logic [WIDTH-1:0] dut_count,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got,
    output logic [15:0]      first_cyc,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0]      LAST_CYC = 16'(RUN_CYCLES - 1);
    localparam logic [15:0]      CYC_ONE  = 16'd1;
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] EXP_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] EXP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic             STOP_EN  = (STOP_ON_ERR != 0);

    state_t             state_r;
    state_t             next_state_s;
    logic               seen_r;
    logic [15:0]        cyc_r;
    logic               arm_s;
    logic               mismatch_s;
    logic               run_end_s;
    logic [ERR_W-1:0]   err_next_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_SYNC;
                else       next_state_s = ST_IDLE;
            end
            ST_SYNC: begin
                if (seen_r && !dut_reset) next_state_s = ST_CHECK;
                else                      next_state_s = ST_SYNC;
            end
            ST_CHECK: begin
                if (run_end_s) next_state_s = ST_DONE;
                else           next_state_s = ST_CHECK;
            end
            ST_DONE: begin
                if (start) next_state_s = ST_SYNC;
                else       next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Control decode: arming, compare result, run termination, saturating error update
    always_comb begin
        arm_s      = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        mismatch_s = 1'b0;
        run_end_s  = 1'b0;
        err_next_s = err_count;
        if (state_r == ST_CHECK) begin
            mismatch_s = (dut_count != expected);
            run_end_s  = (cyc_r == LAST_CYC) || (mismatch_s && STOP_EN);
        end else begin
            mismatch_s = 1'b0;
            run_end_s  = 1'b0;
        end
        if (mismatch_s && (err_count != ERR_MAX)) begin
            err_next_s = err_count + ERR_ONE;
        end else begin
            err_next_s = err_count;
        end
    end

    // Reference count: follows the counter's own reset/enable whenever a run is armed
    always_ff @(posedge clk) begin
        if (reset) begin
            expected <= EXP_ZERO;
        end else if (state_r == ST_IDLE) begin
            expected <= expected;
        end else if (dut_reset) begin
            expected <= EXP_ZERO;
        end else if (dut_enable) begin
            expected <= expected + EXP_ONE;
        end else begin
            expected <= expected;
        end
    end

    // Sync flag and compare-cycle index
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_r <= 1'b0;
            cyc_r  <= 16'd0;
        end else if (arm_s) begin
            seen_r <= 1'b0;
            cyc_r  <= 16'd0;
        end else if ((state_r == ST_SYNC) && dut_reset) begin
            seen_r <= 1'b1;
        end else if (state_r == ST_CHECK) begin
            cyc_r <= cyc_r + CYC_ONE;
        end else begin
            seen_r <= seen_r;
            cyc_r  <= cyc_r;
        end
    end

    // Result registers; err_count never returns to zero within a run, so zero marks "no error yet"
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            err_count <= ERR_ZERO;
            first_exp <= EXP_ZERO;
            first_got <= EXP_ZERO;
            first_cyc <= 16'd0;
        end else begin
            busy <= (next_state_s == ST_SYNC) || (next_state_s == ST_CHECK);
            done <= run_end_s;
            if (arm_s) begin
                pass      <= 1'b0;
                fail      <= 1'b0;
                err_count <= ERR_ZERO;
                first_exp <= EXP_ZERO;
                first_got <= EXP_ZERO;
                first_cyc <= 16'd0;
            end else if (state_r == ST_CHECK) begin
                err_count <= err_next_s;
                if (mismatch_s && (err_count == ERR_ZERO)) begin
                    first_exp <= expected;
                    first_got <= dut_count;
                    first_cyc <= cyc_r;
                end else begin
                    first_exp <= first_exp;
                    first_got <= first_got;
                    first_cyc <= first_cyc;
                end
                if (run_end_s) begin
                    pass <= (err_next_s == ERR_ZERO);
                    fail <= (err_next_s != ERR_ZERO);
                end else begin
                    pass <= pass;
                    fail <= fail;
                end
            end else begin
                err_count <= err_count;
            end
        end
    end

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: a stop-on-error and a count-all instance share stimulus and
// are compared every cycle against a behavioural model; scenario results are pinned by hand.
module tb_counter_checker;

    localparam int RUN     = 50;
    localparam int MOD     = 16;
    localparam int ERR_MAX = 255;
    localparam int M_IDLE  = 0;
    localparam int M_SYNC  = 1;
    localparam int M_CHECK = 2;
    localparam int M_DONE  = 3;

    logic clk;
    logic reset;
    logic start;
    logic dut_reset;
    logic dut_enable;
    logic [3:0] cnt = 4'd0;
    bit   skip_armed;
    bit   cmp_en;

    logic [1:0]  busy_o, done_o, pass_o, fail_o;
    logic [7:0]  err_o  [2];
    logic [3:0]  fexp_o [2];
    logic [3:0]  fgot_o [2];
    logic [15:0] fcyc_o [2];
    logic [3:0]  exp_o  [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int st;
        bit seen;
        int idx;
        int exp_v;
        int err;
        bit pass;
        bit fail;
        bit done;
        int fexp;
        int fgot;
        int fcyc;
    } mdl_t;

    mdl_t m [2];

    counter_checker #(.WIDTH(4), .ERR_W(8), .RUN_CYCLES(RUN), .STOP_ON_ERR(1)) u_stop (
        .clk(clk), .reset(reset), .start(start), .dut_reset(dut_reset),
        .dut_enable(dut_enable), .dut_count(cnt), .busy(busy_o[0]), .done(done_o[0]),
        .pass(pass_o[0]), .fail(fail_o[0]), .err_count(err_o[0]), .first_exp(fexp_o[0]),
        .first_got(fgot_o[0]), .first_cyc(fcyc_o[0]), .expected(exp_o[0])
    );

    counter_checker #(.WIDTH(4), .ERR_W(8), .RUN_CYCLES(RUN), .STOP_ON_ERR(0)) u_cont (
        .clk(clk), .reset(reset), .start(start), .dut_reset(dut_reset),
        .dut_enable(dut_enable), .dut_count(cnt), .busy(busy_o[1]), .done(done_o[1]),
        .pass(pass_o[1]), .fail(fail_o[1]), .err_count(err_o[1]), .first_exp(fexp_o[1]),
        .first_got(fgot_o[1]), .first_cyc(fcyc_o[1]), .expected(exp_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s inst%0d got %0d want %0d at %0t", name, k, got, want, $time);
        end
    endtask

    // Counter under check, with an optional one-shot 5 -> 7 skip fault
    always @(posedge clk) begin
        if (dut_reset) begin
            cnt <= 4'd0;
        end else if (dut_enable) begin
            if (skip_armed && cnt == 4'd5) begin
                cnt <= 4'd7;
                skip_armed = 1'b0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    task automatic model_step(input int k, input bit stop_on_err);
        mdl_t s;
        bit end_run;
        s = m[k];
        end_run = 1'b0;
        if (reset) begin
            s = '{default: 0};
        end else begin
            s.done = 1'b0;
            if (m[k].st != M_IDLE) begin
                if (dut_reset)       s.exp_v = 0;
                else if (dut_enable) s.exp_v = (m[k].exp_v + 1) % MOD;
            end
            case (m[k].st)
                M_IDLE, M_DONE: begin
                    if (start) begin
                        s.st = M_SYNC; s.seen = 1'b0; s.idx = 0; s.err = 0;
                        s.pass = 1'b0; s.fail = 1'b0; s.fexp = 0; s.fgot = 0; s.fcyc = 0;
                    end
                end
                M_SYNC: begin
                    if (dut_reset)      s.seen = 1'b1;
                    else if (m[k].seen) s.st = M_CHECK;
                end
                M_CHECK: begin
                    if (int'(cnt) != m[k].exp_v) begin
                        if (m[k].err == 0) begin
                            s.fexp = m[k].exp_v;
                            s.fgot = int'(cnt);
                            s.fcyc = m[k].idx;
                        end
                        if (m[k].err < ERR_MAX) s.err = m[k].err + 1;
                        if (stop_on_err) end_run = 1'b1;
                    end
                    if (m[k].idx == RUN - 1) end_run = 1'b1;
                    s.idx = m[k].idx + 1;
                    if (end_run) begin
                        s.st = M_DONE; s.done = 1'b1;
                        s.pass = (s.err == 0); s.fail = (s.err != 0);
                    end
                end
                default: s.st = M_IDLE;
            endcase
        end
        m[k] = s;
    endtask

    always @(posedge clk) begin
        model_step(0, 1'b1);
        model_step(1, 1'b0);
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("busy", k, int'(busy_o[k]), int'(m[k].st == M_SYNC || m[k].st == M_CHECK));
                chk("done", k, int'(done_o[k]), int'(m[k].done));
                chk("pass", k, int'(pass_o[k]), int'(m[k].pass));
                chk("fail", k, int'(fail_o[k]), int'(m[k].fail));
                chk("err_count", k, int'(err_o[k]), m[k].err);
                chk("first_exp", k, int'(fexp_o[k]), m[k].fexp);
                chk("first_got", k, int'(fgot_o[k]), m[k].fgot);
                chk("first_cyc", k, int'(fcyc_o[k]), m[k].fcyc);
                chk("expected", k, int'(exp_o[k]), m[k].exp_v);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sync_pulse();
        dut_reset = 1'b1;
        @(negedge clk);
        dut_reset = 1'b0;
    endtask

    task automatic wait_done(input int k, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done_o[k] !== 1'b1 && n < limit);
    endtask

    initial begin
        int n;
        int n0;
        int n1;
        reset = 1'b1; start = 1'b0; dut_reset = 1'b1; dut_enable = 1'b0;
        skip_armed = 1'b0; cmp_en = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        reset = 1'b0; dut_reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", k, int'(busy_o[k]), 0);
            chk("rst_expected", k, int'(exp_o[k]), 0);
        end

        // Scenario 1: clean counter, enable high 20 cycles then low, stray start mid-run
        dut_enable = 1'b1;
        pulse_start();
        sync_pulse();
        @(negedge clk);
        n = 0;
        while (done_o[0] !== 1'b1 && n < 200) begin
            if (n == 20) dut_enable = 1'b0;
            start = (n == 30);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("s1_latency", 0, n, 50);
        for (int k = 0; k < 2; k++) begin
            chk("s1_pass", k, int'(pass_o[k]), 1);
            chk("s1_fail", k, int'(fail_o[k]), 0);
            chk("s1_err", k, int'(err_o[k]), 0);
            chk("s1_expected", k, int'(exp_o[k]), 5);
        end

        // Scenarios 2/3: skip fault; stop-on-error ends at cycle 5, count-all runs full length
        dut_enable = 1'b1;
        pulse_start();
        skip_armed = 1'b1;
        sync_pulse();
        @(negedge clk);
        wait_done(0, 200, n0);
        wait_done(1, 200, n1);
        chk("s2_latency", 0, n0, 6);
        chk("s3_latency", 1, n0 + n1, 50);
        chk("s2_err", 0, int'(err_o[0]), 1);
        chk("s3_err", 1, int'(err_o[1]), 45);
        for (int k = 0; k < 2; k++) begin
            chk("s23_fail", k, int'(fail_o[k]), 1);
            chk("s23_pass", k, int'(pass_o[k]), 0);
            chk("s23_first_exp", k, int'(fexp_o[k]), 6);
            chk("s23_first_got", k, int'(fgot_o[k]), 7);
            chk("s23_first_cyc", k, int'(fcyc_o[k]), 5);
        end

        // Scenario 4: random enable and counter resets on a correct counter
        pulse_start();
        sync_pulse();
        n = 0;
        while (done_o[0] !== 1'b1 && n < 200) begin
            dut_enable = ($urandom_range(0, 2) != 0);
            dut_reset  = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            chk("s4_track", 0, int'(exp_o[0]), int'(cnt));
            n++;
        end
        dut_reset = 1'b0;
        chk("s4_pass", 0, int'(pass_o[0]), 1);
        chk("s4_pass", 1, int'(pass_o[1]), 1);

        // Scenario 5: no counter reset for 30 cycles keeps the run in SYNC
        dut_enable = 1'b1;
        pulse_start();
        for (int i = 0; i < 30; i++) begin
            start = (i == 10);
            @(negedge clk);
            chk("s5_busy", 0, int'(busy_o[0]), 1);
            chk("s5_err", 0, int'(err_o[0]), 0);
        end
        start = 1'b0;
        sync_pulse();
        wait_done(0, 200, n);
        chk("s5_latency", 0, n, 51);
        chk("s5_pass", 0, int'(pass_o[0]), 1);

        // Scenario 6: checker reset mid-CHECK, then a fresh clean run
        pulse_start();
        sync_pulse();
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("s6_busy", k, int'(busy_o[k]), 0);
            chk("s6_done", k, int'(done_o[k]), 0);
            chk("s6_expected", k, int'(exp_o[k]), 0);
        end
        repeat (3) @(negedge clk);
        pulse_start();
        sync_pulse();
        @(negedge clk);
        wait_done(1, 200, n);
        chk("s6_latency", 1, n, 50);
        chk("s6_pass", 1, int'(pass_o[1]), 1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
